// File: rtl/ifu_prefetch.sv
// ifu_prefetch: instruction-fetch unit with an in-order prefetch queue.
// Issues sequential word fetches with up to MAX_OUTSTANDING requests in
// flight. Returned instructions are buffered with their PCs in a DEPTH-entry
// FIFO. A flush redirects the PC, empties the queue, and discards responses
// to requests that were already in flight.
// Optional feature macro: IFU_PREFETCH_PERF_CNT_EN (fetch/drop counters).
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   flush_i, flush_addr_i     : redirect request and word-aligned target
//   stall_i, jtag_halt_i      : stall_i[`STALL_PC] blocks pop; halt blocks issue and pop
//   inst_o, pc_o, inst_valid_o: FIFO head
//   ibus_*                    : instruction bus (read-only word fetches)
//   req_valid_o / req_ready_i : request handshake
//   rsp_valid_i / rsp_ready_o : in-order response handshake
//   fetch_cnt_o, drop_cnt_o   : performance counters (0 unless the macro is defined)
`timescale 1ns/1ps

`ifndef CPU_RESET_ADDR
`define CPU_RESET_ADDR 32'h8000_0000
`endif
`ifndef STALL_WIDTH
`define STALL_WIDTH 3
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module ifu_prefetch #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = `CPU_RESET_ADDR
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [31:0]             flush_addr_i,
  input  logic [`STALL_WIDTH-1:0] stall_i,
  input  logic                    jtag_halt_i,
  output logic [31:0]             inst_o,
  output logic [31:0]             pc_o,
  output logic                    inst_valid_o,
  output logic [31:0]             ibus_addr_o,
  input  logic [31:0]             ibus_data_i,
  output logic [31:0]             ibus_data_o,
  output logic [3:0]              ibus_sel_o,
  output logic                    ibus_we_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  input  logic                    rsp_valid_i,
  output logic                    rsp_ready_o,
  output logic [31:0]             fetch_cnt_o,
  output logic [31:0]             drop_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = CW + OW + 1;

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   rsp_pc, rsp_pc_nxt;
  logic [OW-1:0] outstanding, outstanding_nxt;
  logic [OW-1:0] drop, drop_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [SW-1:0] slots_used;
  logic          credit_ok;
  logic          issue;
  logic          rsp_fire;
  logic          dropping;
  logic          push;
  logic          pop;
  logic          unused_stall;

  // Slots already claimed: FIFO entries plus responses that will be kept.
  // Keeping this below DEPTH guarantees every kept response a free slot.
  assign slots_used = SW'(count) + SW'(outstanding) - SW'(drop);
  assign credit_ok  = slots_used < SW'(DEPTH);

  assign req_valid_o = rst_n & ~flush_i & ~jtag_halt_i &
                       (outstanding < OW'(MAX_OUTSTANDING)) & credit_ok;
  assign rsp_ready_o = rst_n;

  assign issue    = req_valid_o & req_ready_i;
  assign rsp_fire = rsp_valid_i & rsp_ready_o;
  assign dropping = rsp_fire & (drop != '0);
  // A response landing in the flush cycle belongs to the old stream.
  assign push     = rsp_fire & ~dropping & ~flush_i;

  assign inst_valid_o = (count != '0) & ~flush_i;
  assign pop          = inst_valid_o & ~stall_i[`STALL_PC] & ~jtag_halt_i;
  assign inst_o       = inst_valid_o ? inst_mem[rd_ptr] : `INST_NOP;
  assign pc_o         = inst_valid_o ? pc_mem[rd_ptr] : 32'h0;

  assign ibus_addr_o = fetch_pc;
  assign ibus_data_o = 32'h0;
  assign ibus_sel_o  = 4'b1111;
  assign ibus_we_o   = 1'b0;

  assign unused_stall = ^stall_i;

  // Next-state: sequential fetch/response tracking, flush overrides all.
  always_comb begin
    fetch_pc_nxt    = fetch_pc;
    rsp_pc_nxt      = rsp_pc;
    outstanding_nxt = outstanding + OW'(issue) - OW'(rsp_fire);
    drop_nxt        = drop - OW'(dropping);
    count_nxt       = count + CW'(push) - CW'(pop);
    rd_ptr_nxt      = rd_ptr + PW'(pop);
    wr_ptr_nxt      = wr_ptr + PW'(push);
    if (issue) begin
      fetch_pc_nxt = fetch_pc + 32'd4;
    end
    if (push) begin
      rsp_pc_nxt = rsp_pc + 32'd4;
    end
    if (flush_i) begin
      fetch_pc_nxt = flush_addr_i;
      rsp_pc_nxt   = flush_addr_i;
      // Everything still in flight after this cycle's response is stale.
      drop_nxt     = outstanding - OW'(rsp_fire);
      count_nxt    = '0;
      rd_ptr_nxt   = '0;
      wr_ptr_nxt   = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      fetch_pc    <= fetch_pc_nxt;
      rsp_pc      <= rsp_pc_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      count       <= count_nxt;
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= ibus_data_i;
    end
  end

`ifdef IFU_PREFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;

  // Drops: discarded responses plus valid entries cleared by a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      drop_cnt  <= 32'h0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(pop);
      drop_cnt  <= drop_cnt + 32'(dropping | (rsp_fire & flush_i)) +
                   (flush_i ? 32'(count) : 32'h0);
    end
  end

  assign fetch_cnt_o = fetch_cnt;
  assign drop_cnt_o  = drop_cnt;
`else
  assign fetch_cnt_o = 32'h0;
  assign drop_cnt_o  = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: self-checking bench for ifu_prefetch. A bus model answers
// accepted requests in order after a random latency; a queue-level reference
// model (tagged in-flight requests plus a FIFO of {pc, inst}) predicts every
// visible output each cycle.
`timescale 1ns/1ps

`ifndef STALL_WIDTH
`define STALL_WIDTH 3
`endif
`ifndef STALL_PC
`define STALL_PC 0
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_ifu_prefetch;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic                    clk;
  logic                    rst_n;
  logic                    flush_i;
  logic [31:0]             flush_addr_i;
  logic [`STALL_WIDTH-1:0] stall_i;
  logic                    jtag_halt_i;
  logic [31:0]             inst_o;
  logic [31:0]             pc_o;
  logic                    inst_valid_o;
  logic [31:0]             ibus_addr_o;
  logic [31:0]             ibus_data_i;
  logic [31:0]             ibus_data_o;
  logic [3:0]              ibus_sel_o;
  logic                    ibus_we_o;
  logic                    req_valid_o;
  logic                    req_ready_i;
  logic                    rsp_valid_i;
  logic                    rsp_ready_o;
  logic [31:0]             fetch_cnt_o;
  logic [31:0]             drop_cnt_o;

  ifu_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_addr_i(flush_addr_i),
    .stall_i(stall_i), .jtag_halt_i(jtag_halt_i), .inst_o(inst_o), .pc_o(pc_o),
    .inst_valid_o(inst_valid_o), .ibus_addr_o(ibus_addr_o), .ibus_data_i(ibus_data_i),
    .ibus_data_o(ibus_data_o), .ibus_sel_o(ibus_sel_o), .ibus_we_o(ibus_we_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .rsp_valid_i(rsp_valid_i),
    .rsp_ready_o(rsp_ready_o), .fetch_cnt_o(fetch_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        infl[$];
  ent_t        fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_drop_cnt;
  logic [31:0] key;
  int          cyc;
  int          lat_min;
  int          lat_max;
  int          n_cmp;
  int          n_err;
  logic        e_vld;
  logic        e_req;
  logic [162:0] e_vec;
  logic [162:0] o_vec;

  // Predict outputs for the current cycle (inputs already driven).
  task automatic model_eval();
    int          kept;
    logic [31:0] h_pc;
    logic [31:0] h_inst;
    logic [31:0] e_fc;
    logic [31:0] e_dc;
    if (rst_n && infl.size() > 0 && infl[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      ibus_data_i = infl[0].addr ^ key;
    end else begin
      rsp_valid_i = 1'b0;
      ibus_data_i = $urandom;
    end
    #1;
    kept = 0;
    foreach (infl[i]) if (!infl[i].stale) kept++;
    e_vld  = rst_n && fifo.size() > 0 && !flush_i;
    e_req  = rst_n && !flush_i && !jtag_halt_i && infl.size() < MAXO && fifo.size() + kept < DEPTH;
    h_pc   = 32'h0;
    h_inst = `INST_NOP;
    if (e_vld) begin
      h_pc   = fifo[0].pc;
      h_inst = fifo[0].inst;
    end
`ifdef IFU_PREFETCH_PERF_CNT_EN
    e_fc = m_fetch_cnt;
    e_dc = m_drop_cnt;
`else
    e_fc = 32'h0;
    e_dc = 32'h0;
`endif
    e_vec = {e_vld, e_req, rst_n, h_pc, h_inst, e_req ? m_fetch_pc : 32'h0, e_fc, e_dc};
    o_vec = {inst_valid_o, req_valid_o, rsp_ready_o, pc_o, inst_o,
             e_req ? ibus_addr_o : 32'h0, fetch_cnt_o, drop_cnt_o};
  endtask

  // Advance the reference model across the coming clock edge.
  task automatic model_commit();
    bit   pop;
    bit   issue;
    req_t r;
    pop   = e_vld && !stall_i[`STALL_PC] && !jtag_halt_i;
    issue = e_req && req_ready_i;
    if (rsp_valid_i) begin
      r = infl.pop_front();
      if (r.stale || flush_i) m_drop_cnt += 32'd1;
      else fifo.push_back('{r.addr, r.addr ^ key});
    end
    if (pop) begin
      void'(fifo.pop_front());
      m_fetch_cnt += 32'd1;
    end
    if (flush_i) begin
      m_drop_cnt += 32'(fifo.size());
      fifo.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_fetch_pc = flush_addr_i;
    end
    if (issue) begin
      infl.push_back('{m_fetch_pc, cyc + int'($urandom_range(lat_max, lat_min)), 1'b0});
      m_fetch_pc += 32'd4;
    end
    cyc++;
  endtask

  task automatic cyc_begin(input bit f, input logic [31:0] fa, input bit st, input bit h, input bit rdy);
    @(negedge clk);
    flush_i      = f;
    flush_addr_i = fa;
    stall_i      = `STALL_WIDTH'($urandom);
    stall_i[`STALL_PC] = st;
    jtag_halt_i  = h;
    req_ready_i  = rdy;
    model_eval();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rsp_valid_i = 1'b0; flush_i = 1'b0; jtag_halt_i = 1'b0; stall_i = '0; req_ready_i = 1'b1;
    infl.delete(); fifo.delete();
    m_fetch_pc = RPC; m_fetch_cnt = 32'h0; m_drop_cnt = 32'h0;
    #1;
    n_cmp++;
    if ({inst_valid_o, req_valid_o, rsp_ready_o, pc_o, inst_o, fetch_cnt_o, drop_cnt_o} !==
        {3'b000, 32'h0, `INST_NOP, 64'h0}) begin
      n_err++;
      $display("FAIL reset.outputs got vld=%b req=%b rdy=%b pc=%h inst=%h fc=%h dc=%h", inst_valid_o,
               req_valid_o, rsp_ready_o, pc_o, inst_o, fetch_cnt_o, drop_cnt_o);
    end
    n_cmp++;
    if ({ibus_data_o, ibus_sel_o, ibus_we_o} !== {32'h0, 4'hF, 1'b0}) begin
      n_err++;
      $display("FAIL reset.ibus_const got data=%h sel=%h we=%b exp 0/f/0", ibus_data_o, ibus_sel_o, ibus_we_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_eval();
    n_cmp++;
    if (o_vec !== e_vec) begin n_err++; $display("FAIL reset.first_req cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
    n_cmp++;
    if (ibus_addr_o !== RPC) begin n_err++; $display("FAIL reset.first_addr got=%h exp=%h", ibus_addr_o, RPC); end
    model_commit();
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1; key = 32'h0;
    repeat (20) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
  endtask

  task automatic test_fill_stall();
    lat_min = 1; lat_max = 2; key = $urandom;
    for (int i = 0; i < 12; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL fill.stall cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      if (i == 11) begin
        n_cmp++;
        if ({inst_valid_o, req_valid_o} !== 2'b10) begin
          n_err++; $display("FAIL fill.full got vld=%b req=%b exp vld=1 req=0", inst_valid_o, req_valid_o);
        end
      end
      model_commit();
    end
    repeat (10) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL fill.release cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
  endtask

  task automatic test_flush_outstanding();
    bit seen;
    lat_min = 3; lat_max = 3; key = $urandom;
    for (int i = 0; i < 20 && infl.size() < 2; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL flush2.pre cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
    cyc_begin(1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_vec !== e_vec) begin n_err++; $display("FAIL flush2.flush cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
    model_commit();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL flush2.post cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      if (inst_valid_o === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (pc_o !== 32'h100) begin n_err++; $display("FAIL flush2.first_pc got=%h exp=00000100", pc_o); end
      end
      model_commit();
    end
    if (!seen) begin n_cmp++; n_err++; $display("FAIL flush2.timeout no valid instruction after flush"); end
  endtask

  task automatic test_flush_coincident();
    bit hit;
    lat_min = 1; lat_max = 1; key = $urandom;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (infl.size() > 0 && infl[0].due <= cyc && fifo.size() > 0) begin
        hit = 1'b1;
        cyc_begin(1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (inst_valid_o !== 1'b0) begin n_err++; $display("FAIL coinc.valid got=%b exp=0", inst_valid_o); end
      end else begin
        cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      end
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL coinc cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
    if (!hit) begin n_cmp++; n_err++; $display("FAIL coinc.timeout no response/pop overlap found"); end
    repeat (8) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL coinc.post cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
  endtask

  task automatic test_backpressure_halt();
    logic [31:0] held;
    lat_min = 3; lat_max = 3; key = $urandom;
    held = m_fetch_pc;
    repeat (5) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL bp cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      n_cmp++;
      if (ibus_addr_o !== held) begin n_err++; $display("FAIL bp.addr_stable got=%h exp=%h", ibus_addr_o, held); end
      model_commit();
    end
    for (int i = 0; i < 20 && infl.size() != 1; i++) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, infl.size() == 0);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL bp.one cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
    repeat (6) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL halt cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
    repeat (10) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL halt.release cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs[$];
    lat_min = 1; lat_max = 1; key = $urandom;
    cyc_begin(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (o_vec !== e_vec) begin n_err++; $display("FAIL wrap.flush cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
    model_commit();
    repeat (14) begin
      cyc_begin(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      if (inst_valid_o === 1'b1) pcs.push_back(pc_o);
      model_commit();
    end
    n_cmp++;
    if (pcs.size() < 2) begin
      n_err++; $display("FAIL wrap.count got=%0d valid instructions exp>=2", pcs.size());
    end else if (pcs[0] !== 32'hFFFF_FFFC || pcs[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap.pcs got=%h,%h exp=fffffffc,00000000", pcs[0], pcs[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin lat_min = 1; lat_max = 1 + (i / 250) % 4; key = $urandom; end
      if (i == 1000) test_reset();
      cyc_begin($urandom_range(99) < 4, $urandom & 32'hFFFF_FFFC, $urandom_range(99) < 30,
                $urandom_range(99) < 5, $urandom_range(99) < 75);
      n_cmp++;
      if (o_vec !== e_vec) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o_vec, e_vec); end
      model_commit();
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; flush_i = 1'b0; flush_addr_i = 32'h0; stall_i = '0; jtag_halt_i = 1'b0;
    req_ready_i = 1'b1; rsp_valid_i = 1'b0; ibus_data_i = 32'h0;
    lat_min = 1; lat_max = 1; key = 32'h0;
    test_reset();
    test_stream();
    test_fill_stall();
    test_flush_outstanding();
    test_flush_coincident();
    test_backpressure_halt();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with an in-order prefetch queue, a successor to the single-slot fetch stage. It issues sequential word fetches on the instruction bus with up to `MAX_OUTSTANDING` requests in flight. Returned instructions are buffered with their PCs in a `DEPTH`-entry FIFO that decouples bus latency from decode stalls. On a flush it redirects the PC, empties the queue, and silently discards responses to requests already in flight.

## Interface
Parameters:
- `DEPTH`, default 4: prefetch FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, default 2: maximum issued-but-unanswered requests; 1..`DEPTH`.
- `RESET_PC`, default `` `CPU_RESET_ADDR ``: PC after reset.

Ports:
- `clk` input 1: clock; single clock domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush_i` input 1: redirect request.
- `flush_addr_i` input 32: redirect target, word-aligned.
- `stall_i` input `` `STALL_WIDTH ``: pipeline stall; only bit `` `STALL_PC `` is used, and it blocks pop.
- `jtag_halt_i` input 1: blocks both issue and pop.
- `inst_o` output 32: head instruction; `` `INST_NOP `` when not valid.
- `pc_o` output 32: PC of the head instruction; 0 when not valid.
- `inst_valid_o` output 1: head is valid this cycle.
- `ibus_addr_o` output 32: fetch address (= fetch PC).
- `ibus_data_i` input 32: response data.
- `ibus_data_o` output 32: constant 0.
- `ibus_sel_o` output 4: constant 4'b1111.
- `ibus_we_o` output 1: constant 0.
- `req_valid_o` output 1: request valid.
- `req_ready_i` input 1: request accepted.
- `rsp_valid_i` input 1: response valid; responses arrive in order.
- `rsp_ready_o` output 1: 0 in reset, otherwise 1.
- `fetch_cnt_o` output 32: performance counter (see Configuration).
- `drop_cnt_o` output 32: performance counter (see Configuration).

## Operation

**State**
- `fetch_pc`: next address to request.
- `rsp_pc`: PC of the next kept response.
- `outstanding`: issued requests not yet answered, 0..`MAX_OUTSTANDING`.
- `drop`: responses still to be discarded.
- FIFO of {pc, inst} with `count`.

**Issue**
- `req_valid_o` = `rst_n & ~flush_i & ~jtag_halt_i & (outstanding < MAX_OUTSTANDING) & (count + outstanding - drop < DEPTH)`.
- The last term is the credit check. Every kept response is guaranteed a FIFO slot, so `rsp_ready_o` never deasserts.
- Issue handshake (`req_valid_o & req_ready_i`):
  - `fetch_pc += 4`, wrapping modulo 2^32.
  - `outstanding++`.

**Response** (`rsp_valid_i & rsp_ready_o`):
- Always `outstanding--`. Issue and response in the same cycle leave `outstanding` unchanged.
- If `drop > 0`: `drop--`; data is discarded.
- Else: push {`rsp_pc`, `ibus_data_i`} and `rsp_pc += 4`.

**Pop**
- Pop condition: `inst_valid_o & ~stall_i[STALL_PC] & ~jtag_halt_i`.
- Push and pop may occur in the same cycle, including at full and empty.

**Flush** (highest priority)
- At the clock edge:
  - FIFO is emptied.
  - `fetch_pc` and `rsp_pc` are loaded with `flush_addr_i`.
  - `drop` is loaded with `outstanding` after this cycle's response. A response arriving in the flush cycle is itself discarded.
- During the flush cycle:
  - No push.
  - `inst_valid_o = 0`.
  - `req_valid_o = 0`.
- Back-to-back flushes: the last one wins, and `drop` accumulates correctly.

**Reset values**
- `fetch_pc` and `rsp_pc` = `RESET_PC`.
- `outstanding`, `drop` and `count` = 0.
- Outputs: `req_valid_o = 0`, `rsp_ready_o = 0`, `inst_valid_o = 0`, `inst_o` = `` `INST_NOP ``, `pc_o = 0`, counters = 0.
- Reset mid-operation abandons all in-flight state immediately.

## Timing
- The FIFO is registered. A response accepted at edge N appears on `inst_valid_o` and `inst_o` in cycle N+1.
- The first request is driven in the first cycle with `rst_n` high, at `RESET_PC`.
- Flush asserted in cycle F: the first request to `flush_addr_i` is in cycle F+1. The first valid instruction comes no earlier than one cycle after its non-dropped response.
- Sustained throughput with a zero-wait bus and no stall: one instruction per cycle.
- `req_valid_o`, `inst_valid_o`, `inst_o` and `pc_o` are combinational from registered state plus `flush_i`, `jtag_halt_i` and `stall_i`. There is no combinational path from `rsp_valid_i`.

## Configuration
Macro: `IFU_PREFETCH_PERF_CNT_EN`.
- **Defined:**
  - `fetch_cnt_o` increments on every pop.
  - `drop_cnt_o` increments on every discarded response plus every valid FIFO entry cleared by a flush. It adds `count` at the flush edge; a pop in the flush cycle does not occur.
  - Both counters wrap at 2^32 and reset to 0.
- **Undefined:**
  - Both ports are tied to 0.
  - No counter registers are synthesised.

## Test plan
- **Reset and stream:**
  - Stimulus: reset with `RESET_PC` = 0x8000_0000, zero-wait memory returning data = addr, no stall.
  - Expected: `inst_valid_o` high every cycle from the 2nd response onward, with `pc_o`/`inst_o` = 0x8000_0000, 0x8000_0004, ….
- **Fill with stall:**
  - Stimulus: hold `stall_i[STALL_PC]` with `DEPTH` = 4.
  - Expected: `count` reaches 4, then `req_valid_o` = 0. Releasing the stall pops 4 consecutive PCs with no gap or duplicate.
- **Flush with 2 outstanding:**
  - Stimulus: 2 requests unanswered (3-cycle response latency), then flush to 0x100.
  - Expected: the next 2 responses are dropped. The first `inst_valid_o` shows `pc_o` = 0x100. `drop_cnt_o` increments by 2 + prior `count`.
- **Flush coincident with response and pop:**
  - Expected: that response is discarded, `inst_valid_o` = 0 in that cycle, and `fetch_cnt_o` is unchanged.
- **Backpressure and halt:**
  - Stimulus: `req_ready_i` low for 5 cycles, then assert `jtag_halt_i` with 1 outstanding.
  - Expected: `ibus_addr_o` stays stable while blocked. The outstanding response is still pushed, no new request or pop occurs, and operation resumes at the next PC on release.
- **Wrap:**
  - Stimulus: flush to 0xFFFF_FFFC.
  - Expected: next PCs are 0xFFFF_FFFC, then 0x0000_0000.
